sll_reg: RTL and testbench

//   Registered shift-logical-left unit for the architecture elements catalog.

---
 rtl/sll_reg.sv | 50 +++++
 tb/tb_sll_reg.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sll_reg.sv
// Registered shift-logical-left: out <= d << amt (zero fill, truncated) when en, else hold.
// One-cycle latency, no handshake; async active-low rst clears the result register.
module sll_reg #(
  parameter int n  = 8,
  parameter int aw = $clog2(n)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [n-1:0]  d,
  input  logic [aw-1:0] amt,
  output logic [n-1:0]  out
);

  logic [n-1:0] shifted;
  logic         amt_in_range;
  logic [n-1:0] out_d;
  logic [n-1:0] out_q;

  // amt can only reach n or beyond when n is not a power of two
  assign amt_in_range = ({1'b0, amt} < (aw + 1)'(n));

  // Log2 barrel shifter: stage k moves the operand by 2^k when amt[k] is set
  always_comb begin
    shifted = d;
    for (int k = 0; k < aw; k++) begin
      if (amt[k]) begin
        shifted = shifted << (1 << k);
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (en) begin
      out_d = amt_in_range ? shifted : '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_sll_reg.sv
// Self-checking bench for sll_reg (n=8): expected results queued at drive time, popped after each edge.
module tb_sll_reg;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] d;
  logic [2:0] amt;
  logic [7:0] out;

  int         assertions;
  int         failures;
  logic [7:0] model_out;
  logic [7:0] sb[$];
  logic [7:0] exp_v;

  sll_reg #(.n(8)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .d   (d),
    .amt (amt),
    .out (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference shift built bit by bit, independent of the barrel structure
  function automatic logic [7:0] ref_sll(input logic [7:0] v, input logic [2:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(a)) r[i] = v[i - int'(a)];
    end
    return r;
  endfunction

  // Drive one cycle's inputs at the falling edge, record the expectation, settle after the rising edge
  task automatic drive(input logic [7:0] dv, input logic [2:0] av, input logic ev);
    @(negedge clk);
    d   = dv;
    amt = av;
    en  = ev;
    if (ev) model_out = ref_sll(dv, av);
    sb.push_back(model_out);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    d   = 8'hFF;
    amt = 3'd1;
    en  = 1'b1;
    model_out = 8'h00;
    #2;
    assertions++;
    if (out !== 8'h00) begin
      failures++;
      $display("FAIL reset_initial: out=%h expected 00", out);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      assertions++;
      if (out !== 8'h00) begin
        failures++;
        $display("FAIL reset_hold_%0d: out=%h expected 00", i, out);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
  endtask

  task automatic test_basic();
    drive(8'b0000_0101, 3'd2, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== exp_v || out !== 8'b0001_0100) begin
      failures++;
      $display("FAIL basic_shift2: out=%h expected %h", out, exp_v);
    end
  endtask

  task automatic test_extremes();
    drive(8'hFF, 3'd7, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== exp_v || out !== 8'h80) begin
      failures++;
      $display("FAIL shift_max: out=%h expected %h", out, exp_v);
    end
    drive(8'hFF, 3'd0, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== exp_v || out !== 8'hFF) begin
      failures++;
      $display("FAIL shift_zero: out=%h expected %h", out, exp_v);
    end
    drive(8'h01, 3'd7, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== 8'h80) begin
      failures++;
      $display("FAIL lsb_to_msb: out=%h expected 80", out);
    end
  endtask

  task automatic test_hold();
    drive(8'h3C, 3'd0, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== 8'h3C) begin
      failures++;
      $display("FAIL hold_load: out=%h expected 3c", out);
    end
    for (int i = 0; i < 3; i++) begin
      drive(8'hAA, 3'd1, 1'b0);
      exp_v = sb.pop_front();
      assertions++;
      if (out !== exp_v || out !== 8'h3C) begin
        failures++;
        $display("FAIL hold_%0d: out=%h expected %h", i, out, exp_v);
      end
    end
    // Inputs moving between edges must not disturb the register
    #2;
    d   = 8'h55;
    amt = 3'd3;
    en  = 1'b1;
    #1;
    assertions++;
    if (out !== 8'h3C) begin
      failures++;
      $display("FAIL mid_cycle_change: out=%h expected 3c", out);
    end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 256; v++) begin
      drive(8'(v), 3'd2, 1'b1);
      exp_v = sb.pop_front();
      assertions++;
      if (out !== exp_v || out !== 8'((v * 4) & 8'hFF)) begin
        failures++;
        $display("FAIL sweep_d%0d: out=%h expected %h", v, out, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rd;
    logic [2:0] ra;
    logic       re;
    for (int i = 0; i < 40; i++) begin
      rd = 8'($urandom_range(0, 255));
      ra = 3'($urandom_range(0, 7));
      re = 1'($urandom_range(0, 3) != 0);
      drive(rd, ra, re);
      exp_v = sb.pop_front();
      assertions++;
      if (out !== exp_v) begin
        failures++;
        $display("FAIL b2b_%0d: d=%h amt=%0d en=%b out=%h expected %h", i, rd, ra, re, out, exp_v);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(8'hFF, 3'd7, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== 8'h80) begin
      failures++;
      $display("FAIL areset_preload: out=%h expected 80", out);
    end
    #2;
    rst = 1'b0;
    model_out = 8'h00;
    #1;
    assertions++;
    if (out !== 8'h00) begin
      failures++;
      $display("FAIL areset_immediate: out=%h expected 00", out);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    assertions++;
    if (out !== 8'h00) begin
      failures++;
      $display("FAIL areset_release: out=%h expected 00", out);
    end
    drive(8'h01, 3'd3, 1'b1);
    exp_v = sb.pop_front();
    assertions++;
    if (out !== exp_v || out !== 8'h08) begin
      failures++;
      $display("FAIL areset_reload: out=%h expected %h", out, exp_v);
    end
  endtask

  initial begin
    assertions = 0;
    failures   = 0;
    model_out  = 8'h00;
    rst = 1'b1;
    en  = 1'b0;
    d   = 8'h00;
    amt = 3'd0;
    test_reset();
    test_basic();
    test_extremes();
    test_hold();
    test_sweep();
    test_back_to_back();
    test_async_reset();
    assertions++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: entries=%0d expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
